// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; define MEM_ARB_STARVE_GUARD_EN for the fetch starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t state;
  logic if_pend, d_pend, starved, grant_if, grant_d;
  // a requester whose ack is high this cycle still shows its old req, so it is masked
  assign if_pend = if_req & ~if_ack;
  assign d_pend = d_req & ~d_ack;
  assign stall_if = if_pend;
  assign stall_mem = d_pend;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  assign starved = if_pend && starve_cnt == CW'(STARVE_LIMIT);
  // count data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (rst || grant_if || !if_req) starve_cnt <= '0;
    else if (grant_d && if_pend) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starved = 1'b0;
`endif
  // fetch needs a quiet d_req line (stale or not) unless it has been starved
  assign grant_if = state == IDLE && if_pend && (starved || !d_req);
  assign grant_d = state == IDLE && d_pend && !grant_if;
  // sequencer: grant, hold the port stable, complete on mem_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == IDLE) begin
        if (grant_d) begin
          state <= BUSY_D;
          mem_req <= 1'b1;
          mem_we <= d_we;
          mem_addr <= d_addr;
          mem_wdata <= d_wdata;
          mem_wstrb <= d_we ? d_wstrb : '0;
        end else if (grant_if) begin
          state <= BUSY_IF;
          mem_req <= 1'b1;
          mem_we <= 1'b0;
          mem_addr <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      end else if (mem_ready) begin
        state <= IDLE;
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_ack <= 1'b1;
        end else begin
          d_rdata <= mem_rdata;
          d_ack <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_if, stall_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // reference state for the random phase: golden memory seen by requesters, memory behind the port
  logic [31:0] gold [8];
  logic [31:0] resp [8];
  bit          if_out, d_out, d_is_we;
  logic [2:0]  if_idx, d_idx;
  logic [31:0] d_wd;
  logic [3:0]  d_ws;
  int          issued_if, issued_d, acks_if, acks_d;

  task automatic rand_cycle(input bit allow_new);
    tick;
    if (if_ack) begin
      chk("rand_if_ack_expected", 32'(if_out), 32'd1);
      chk("rand_if_rdata", if_rdata, gold[if_idx]);
      acks_if++;
      if_out = 1'b0;
      if_req = 1'b0;
    end
    if (d_ack) begin
      chk("rand_d_ack_expected", 32'(d_out), 32'd1);
      if (d_is_we) gold[d_idx] = merge(gold[d_idx], d_wd, d_ws);
      else chk("rand_d_rdata", d_rdata, gold[d_idx]);
      acks_d++;
      d_out = 1'b0;
      d_req = 1'b0;
    end
    if (allow_new && !if_out && $urandom_range(0, 2) == 0) begin
      if_out = 1'b1;
      if_idx = 3'($urandom_range(0, 7));
      if_addr = {27'd0, if_idx, 2'b00};
      if_req = 1'b1;
      issued_if++;
    end
    if (allow_new && !d_out && $urandom_range(0, 2) == 0) begin
      d_out = 1'b1;
      d_idx = 3'($urandom_range(0, 7));
      d_is_we = 1'($urandom_range(0, 1));
      d_wd = $urandom;
      d_ws = 4'($urandom_range(0, 15));
      d_addr = {27'd0, d_idx, 2'b00};
      d_we = d_is_we;
      d_wdata = d_wd;
      d_wstrb = d_ws;
      d_req = 1'b1;
      issued_d++;
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = mem_req ? resp[mem_addr[4:2]] : $urandom;
    if (mem_req && mem_ready && mem_we) resp[mem_addr[4:2]] = merge(resp[mem_addr[4:2]], mem_wdata, mem_wstrb);
    #1;
    chk("rand_stall_if", 32'(stall_if), 32'(if_req && !if_ack));
    chk("rand_stall_mem", 32'(stall_mem), 32'(d_req && !d_ack));
  endtask

  int nd, nf;

  initial begin
    // reset then idle
    tick;
    tick;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_acks", 32'({if_ack, d_ack}), 32'd0);
    end
    // lone fetch, zero-wait
    if_req = 1'b1;
    if_addr = 32'h100;
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    #1;
    chk("fetch_stall_n", 32'(stall_if), 32'd1);
    tick;
    chk("fetch_mem_req", 32'(mem_req), 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h100);
    chk("fetch_mem_we", 32'(mem_we), 32'd0);
    chk("fetch_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("fetch_ack_early", 32'(if_ack), 32'd0);
    chk("fetch_stall_n1", 32'(stall_if), 32'd1);
    tick;
    chk("fetch_ack", 32'(if_ack), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    chk("fetch_mem_req_drop", 32'(mem_req), 32'd0);
    chk("fetch_stall_n2", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    mem_ready = 1'b0;
    tick;
    chk("fetch_ack_pulse", 32'(if_ack), 32'd0);
    // store with three wait states
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("store_mem_req", 32'(mem_req), 32'd1);
      chk("store_mem_we", 32'(mem_we), 32'd1);
      chk("store_mem_addr", mem_addr, 32'h200);
      chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("store_mem_wstrb", 32'(mem_wstrb), 32'hF);
      chk("store_no_ack", 32'(d_ack), 32'd0);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick;
    chk("store_ack", 32'(d_ack), 32'd1);
    chk("store_rdata", d_rdata, 32'h1234_5678);
    chk("store_mem_req_drop", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    mem_ready = 1'b0;
    tick;
    chk("store_ack_pulse", 32'(d_ack), 32'd0);
    // simultaneous requests: data first, fetch in the d_ack cycle
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    if_req = 1'b1;
    if_addr = 32'h300;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h400;
    d_wstrb = 4'hF;
    tick;
    chk("conf_first_addr", mem_addr, 32'h400);
    chk("conf_load_wstrb", 32'(mem_wstrb), 32'd0);
    chk("conf_load_we", 32'(mem_we), 32'd0);
    tick;
    chk("conf_d_ack", 32'({if_ack, d_ack}), 32'b01);
    chk("conf_d_rdata", d_rdata, 32'hAAAA_0001);
    d_req = 1'b0;
    mem_rdata = 32'hBBBB_0002;
    tick;
    chk("conf_fetch_granted", 32'(mem_req), 32'd1);
    chk("conf_fetch_addr", mem_addr, 32'h300);
    chk("conf_no_ack", 32'({if_ack, d_ack}), 32'b00);
    tick;
    chk("conf_if_ack", 32'({if_ack, d_ack}), 32'b10);
    chk("conf_if_rdata", if_rdata, 32'hBBBB_0002);
    if_req = 1'b0;
    tick;
    chk("conf_single_ack", 32'({if_ack, d_ack}), 32'b00);
    tick;
    // starvation: d_req stays high with a new address after each ack
    mem_ready = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h500;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h1000;
    nd = 0;
    nf = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (nf == 0) begin
        if (d_ack) begin
          nd++;
          d_addr = d_addr + 32'd4;
        end
        if (if_ack) begin
          nf = 1;
          if_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_data_grants", 32'(nd), 32'd4);
    chk("starve_fetch_granted", 32'(nf), 32'd1);
`else
    chk("strict_no_fetch", 32'(nf), 32'd0);
    chk("strict_data_flow", 32'(nd >= 5), 32'd1);
`endif
    d_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (if_ack) begin
        nf = 1;
        if_req = 1'b0;
      end
    end
    chk("starve_fetch_eventually", 32'(nf), 32'd1);
    // reset mid-access
    mem_ready = 1'b0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h600;
    tick;
    chk("rstmid_busy", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rstmid_no_ack", 32'(d_ack), 32'd0);
      chk("rstmid_idle", 32'(mem_req), 32'd0);
    end
    // randomized traffic against the golden memory
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gold[i] = $urandom;
      resp[i] = gold[i];
    end
    if_out = 1'b0;
    d_out = 1'b0;
    issued_if = 0;
    issued_d = 0;
    acks_if = 0;
    acks_d = 0;
    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    for (int i = 0; i < 60 && (if_out || d_out); i++) rand_cycle(1'b0);
    chk("rand_drained", 32'({if_out, d_out}), 32'd0);
    chk("rand_if_acks", 32'(acks_if), 32'(issued_if));
    chk("rand_d_acks", 32'(acks_d), 32'(issued_d));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
